// File: rtl/axi_mem_slave.sv
// AXI3-style memory responder with independent write (AW/W/B) and read (AR/R) paths.
// Optional macro AXI_SLAVE_WID_CHECK_EN: compare each WID against the latched AWID.
module axi_mem_slave #(
  parameter int unsigned ID_WIDTH   = 5,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [ID_WIDTH-1:0]    AWID,
  input  logic [ADDR_WIDTH-1:0]  AWADDR,
  input  logic [3:0]             AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic [1:0]             AWLOCK,
  input  logic [3:0]             AWCACHE,
  input  logic [2:0]             AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [ID_WIDTH-1:0]    WID,
  input  logic [BUS_WIDTH-1:0]   WDATA,
  input  logic [BUS_WIDTH/8-1:0] WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [ID_WIDTH-1:0]    BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [ID_WIDTH-1:0]    ARID,
  input  logic [ADDR_WIDTH-1:0]  ARADDR,
  input  logic [3:0]             ARLEN,
  input  logic [2:0]             ARSIZE,
  input  logic [1:0]             ARBURST,
  input  logic [1:0]             ARLOCK,
  input  logic [3:0]             ARCACHE,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [ID_WIDTH-1:0]    RID,
  output logic [BUS_WIDTH-1:0]   RDATA,
  output logic [3:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = BUS_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIM  = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC  = ADDR_WIDTH'(4);
  localparam logic [2:0]            SIZE_4B   = 3'b010;
  localparam logic [1:0]            RESP_OKAY = 2'b00;
  localparam logic [1:0]            RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Only 4-byte beats with FIXED or INCR bursts are served.
  function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || burst[1];
  endfunction

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  logic unused_attr;
  assign unused_attr = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  wbad_q, wbad_d, wfixed_q, wfixed_d, werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_beat_c, w_beat_err_c, wid_err_c, wlast_err_c, mem_we_c;

`ifdef AXI_SLAVE_WID_CHECK_EN
  assign wid_err_c = (WID != awid_q);
`else
  logic unused_wid;
  assign unused_wid = ^WID;
  assign wid_err_c  = 1'b0;
`endif

  assign w_beat_c     = (w_state_q == W_DATA) && WVALID;
  assign w_beat_err_c = wbad_q || (waddr_q >= ADDR_LIM) || wid_err_c;
  assign wlast_err_c  = WLAST != (wcnt_q == 4'd0);
  assign mem_we_c     = w_beat_c && !w_beat_err_c;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      wcnt_q    <= '0;
      wbad_q    <= 1'b0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wcnt_q    <= wcnt_d;
      wbad_q    <= wbad_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Beat counter, not WLAST, ends the burst.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    wcnt_d    = wcnt_q;
    wbad_d    = wbad_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    unique case (w_state_q)
      W_IDLE: if (AWVALID) begin
        w_state_d = W_DATA;
        awid_d    = AWID;
        waddr_d   = AWADDR;
        wcnt_d    = AWLEN;
        wbad_d    = bad_attr(AWSIZE, AWBURST);
        wfixed_d  = (AWBURST == 2'b00);
        werr_d    = 1'b0;
      end
      W_DATA: if (WVALID) begin
        if (w_beat_err_c || wlast_err_c) werr_d = 1'b1;
        waddr_d = wfixed_q ? waddr_q : waddr_q + BEAT_INC;
        wcnt_d  = wcnt_q - 4'd1;
        if (wcnt_q == 4'd0) w_state_d = W_RESP;
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    if ((w_state_q == W_DATA) && (w_state_d == W_RESP)) begin
      bid_d   = awid_q;
      bresp_d = werr_d ? RESP_SLV : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[waddr_q[IDX_W+1:2]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic                  rbad_q, rbad_d, rfixed_q, rfixed_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_first_c, r_hs_c, r_next_c, rd_err_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [BUS_WIDTH-1:0]  rd_word_c;

  assign r_first_c = (r_state_q == R_IDLE) && ARVALID;
  assign r_hs_c    = (r_state_q == R_DATA) && RREADY;
  assign r_next_c  = r_hs_c && (rcnt_q != 4'd0);
  assign rd_addr_c = (r_state_q == R_IDLE) ? ARADDR : raddr_q;
  assign rd_err_c  = ((r_state_q == R_IDLE) ? bad_attr(ARSIZE, ARBURST) : rbad_q)
                     || (rd_addr_c >= ADDR_LIM);
  assign rd_word_c = mem[rd_addr_c[IDX_W+1:2]];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rbad_q    <= 1'b0;
      rfixed_q  <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rbad_q    <= rbad_d;
      rfixed_q  <= rfixed_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // raddr_q always holds the address of the next beat to be loaded.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rbad_d    = rbad_q;
    rfixed_d  = rfixed_q;
    unique case (r_state_q)
      R_IDLE: if (ARVALID) begin
        r_state_d = R_DATA;
        rcnt_d    = ARLEN;
        rbad_d    = bad_attr(ARSIZE, ARBURST);
        rfixed_d  = (ARBURST == 2'b00);
        raddr_d   = (ARBURST == 2'b00) ? ARADDR : ARADDR + BEAT_INC;
      end
      R_DATA: if (RREADY) begin
        if (rcnt_q == 4'd0) begin
          r_state_d = R_IDLE;
        end else begin
          rcnt_d  = rcnt_q - 4'd1;
          raddr_d = rfixed_q ? raddr_q : raddr_q + BEAT_INC;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rid_d     = r_first_c ? ARID : rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (r_first_c || r_next_c) begin
      rdata_d = rd_err_c ? '0 : rd_word_c;
      rresp_d = rd_err_c ? RESP_SLV : RESP_OKAY;
      rlast_d = r_first_c ? (ARLEN == 4'd0) : (rcnt_q == 4'd1);
    end else if (r_hs_c) begin
      rlast_d = 1'b0;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = {2'b00, rresp_q};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a word-array reference model.
module tb_axi_mem_slave;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] LIM   = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic clr;
  logic [4:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, AWCACHE, ARCACHE, WSTRB, RRESP;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 clk = ~clk;

  axi_mem_slave #(.ID_WIDTH(5), .ADDR_WIDTH(32), .BUS_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  logic [4:0]  wb_wid  [16];
  logic [31:0] rb_data [16];
  logic [3:0]  rb_resp [16];
  logic        rb_last [16];
  logic [4:0]  rb_id   [16];
  logic [31:0] ex_data [16];
  logic [3:0]  ex_resp [16];

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic bit beat_bad(input logic [2:0] size, input logic [1:0] burst, input logic [31:0] a);
    return (size != 3'd2) || !(burst == 2'b00 || burst == 2'b01) || (a >= LIM);
  endfunction

  task automatic model_write(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit wlast_bad,
                             output logic [1:0] exp_bresp);
    bit err, skip;
    logic [31:0] a;
    logic [7:0] idx;
    err = wlast_bad;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      skip = beat_bad(size, burst, a);
`ifdef AXI_SLAVE_WID_CHECK_EN
      if (wb_wid[i] !== id) skip = 1'b1;
`endif
      if (skip) err = 1'b1;
      else begin
        idx = a[9:2];
        for (int b = 0; b < 4; b++)
          if (wb_strb[i][b]) ref_mem[idx][b*8 +: 8] = wb_data[i][b*8 +: 8];
      end
    end
    exp_bresp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic [7:0] idx;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      idx = a[9:2];
      ex_data[i] = beat_bad(size, burst, a) ? 32'h0 : ref_mem[idx];
      ex_resp[i] = beat_bad(size, burst, a) ? 4'h2 : 4'h0;
    end
  endtask

  task automatic set_wid(input logic [4:0] id);
    for (int i = 0; i < 16; i++) wb_wid[i] = id;
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit wlast_bad,
                          input int bdelay, output logic [4:0] bid, output logic [1:0] bresp,
                          output int unstable, output logic aw_busy, output logic wready_n1,
                          output logic bvalid_k1, output logic awready_after);
    int t;
    logic [4:0] b0;
    logic [1:0] r0;
    unstable = 0;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; failures++; $display("FAIL aw_timeout awready=%b required 1", AWREADY); end
    @(negedge clk);
    AWVALID = 1'b0;
    aw_busy = AWREADY;
    wready_n1 = WREADY;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = wb_data[i]; WSTRB = wb_strb[i]; WID = wb_wid[i];
      WLAST = wlast_bad ? (i != int'(len)) : (i == int'(len));
      t = 0;
      while (!WREADY && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin checks++; failures++; $display("FAIL w_timeout beat=%0d wready=%b required 1", i, WREADY); end
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    bvalid_k1 = BVALID;
    b0 = BID; r0 = BRESP;
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      if (BVALID !== 1'b1 || BID !== b0 || BRESP !== r0) unstable++;
    end
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; failures++; $display("FAIL b_timeout bvalid=%b required 1", BVALID); end
    bid = BID; bresp = BRESP;
    @(negedge clk);
    BREADY = 1'b0;
    awready_after = AWREADY;
  endtask

  // mode 0: RREADY high, 1: toggle 1/0, 2: random
  task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         output int nbeats, output int unstable, output logic rvalid_n1,
                         output logic rvalid_after, output logic arready_after);
    int t;
    bit stalled, rr;
    logic [31:0] sd;
    logic [3:0] sr;
    logic sl;
    logic [4:0] si;
    unstable = 0;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin checks++; failures++; $display("FAIL ar_timeout arready=%b required 1", ARREADY); end
    @(negedge clk);
    ARVALID = 1'b0;
    rvalid_n1 = RVALID;
    nbeats = 0; t = 0; stalled = 1'b0;
    sd = '0; sr = '0; sl = 1'b0; si = '0;
    while (nbeats <= int'(len) && t < 400) begin
      if (stalled && (RVALID !== 1'b1 || RDATA !== sd || RLAST !== sl || RRESP !== sr || RID !== si))
        unstable++;
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
      RREADY = rr;
      stalled = 1'b0;
      if (RVALID) begin
        if (rr) begin
          rb_data[nbeats] = RDATA; rb_resp[nbeats] = RRESP;
          rb_last[nbeats] = RLAST; rb_id[nbeats] = RID;
          nbeats++;
        end else begin
          stalled = 1'b1; sd = RDATA; sr = RRESP; sl = RLAST; si = RID;
        end
      end
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin checks++; failures++; $display("FAIL r_timeout beats=%0d required %0d", nbeats, int'(len) + 1); end
    RREADY = 1'b0;
    rvalid_after = RVALID;
    arready_after = ARREADY;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++; if ({AWREADY, ARREADY} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b required 11", {AWREADY, ARREADY}); end
    checks++; if ({WREADY, BVALID, RVALID, RLAST} !== 4'b0) begin failures++; $display("FAIL reset_valids got=%b required 0000", {WREADY, BVALID, RVALID, RLAST}); end
    checks++; if ({BID, BRESP, RID, RRESP} !== 16'h0) begin failures++; $display("FAIL reset_ids got=%h required 0", {BID, BRESP, RID, RRESP}); end
    checks++; if (RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h required 0", RDATA); end
  endtask

  task automatic test_fill();
    logic [4:0] bid; logic [1:0] bresp, eb; int un; logic x0, x1, x2, x3;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
      set_wid(5'(k));
      do_write(5'(k), 32'(k * 64), 4'hF, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
      model_write(5'(k), 32'(k * 64), 4'hF, 3'd2, 2'b01, 1'b0, eb);
      checks++; if (bresp !== eb || bid !== 5'(k)) begin failures++; $display("FAIL fill_b k=%0d got bid=%h bresp=%b required bid=%h bresp=%b", k, bid, bresp, 5'(k), eb); end
    end
  endtask

  task automatic test_incr_basic();
    logic [4:0] bid; logic [1:0] bresp, eb; int un, nb; logic aw_busy, wr1, bv1, awa, rv1, rva, ara;
    for (int i = 0; i < 4; i++) begin wb_data[i] = 32'hA0 + 32'(i); wb_strb[i] = 4'hF; end
    set_wid(5'h0A);
    do_write(5'h0A, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, aw_busy, wr1, bv1, awa);
    model_write(5'h0A, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0, eb);
    checks++; if (bresp !== 2'b00 || bid !== 5'h0A) begin failures++; $display("FAIL incr_b got bid=%h bresp=%b required bid=0a bresp=00", bid, bresp); end
    checks++; if ({aw_busy, wr1, bv1, awa} !== 4'b0111) begin failures++; $display("FAIL write_timing got aw_busy,wready,bvalid,awready=%b required 0111", {aw_busy, wr1, bv1, awa}); end
    do_read(5'h15, 32'h10, 4'd3, 3'd2, 2'b01, 0, nb, un, rv1, rva, ara);
    checks++; if ({rv1, rva, ara} !== 3'b101) begin failures++; $display("FAIL read_timing got rvalid1,rvalid_after,arready=%b required 101", {rv1, rva, ara}); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rb_data[i] !== 32'hA0 + 32'(i) || rb_last[i] !== (i == 3) || rb_resp[i] !== 4'h0 || rb_id[i] !== 5'h15) begin
        failures++;
        $display("FAIL incr_read beat=%0d got data=%h last=%b resp=%h id=%h required data=%h last=%b resp=0 id=15",
                 i, rb_data[i], rb_last[i], rb_resp[i], rb_id[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [4:0] bid; logic [1:0] bresp, eb; int un, nb; logic x0, x1, x2, x3, y0, y1, y2;
    set_wid(5'h01);
    wb_data[0] = 32'h0; wb_strb[0] = 4'hF;
    do_write(5'h01, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h01, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, eb);
    wb_data[0] = 32'hFFFF_FFFF; wb_strb[0] = 4'b0101;
    do_write(5'h01, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h01, 32'h40, 4'd0, 3'd2, 2'b01, 1'b0, eb);
    do_read(5'h02, 32'h40, 4'd0, 3'd2, 2'b01, 0, nb, un, y0, y1, y2);
    checks++; if (rb_data[0] !== 32'h00FF_00FF || rb_last[0] !== 1'b1) begin failures++; $display("FAIL strobe got data=%h last=%b required data=00ff00ff last=1", rb_data[0], rb_last[0]); end
  endtask

  task automatic test_fixed_and_size();
    logic [4:0] bid; logic [1:0] bresp, eb; int un, nb; logic x0, x1, x2, x3, y0, y1, y2;
    for (int i = 0; i < 3; i++) begin wb_data[i] = 32'(i + 1); wb_strb[i] = 4'hF; end
    set_wid(5'h04);
    do_write(5'h04, 32'h20, 4'd2, 3'd2, 2'b00, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h04, 32'h20, 4'd2, 3'd2, 2'b00, 1'b0, eb);
    do_read(5'h04, 32'h20, 4'd0, 3'd2, 2'b01, 0, nb, un, y0, y1, y2);
    checks++; if (rb_data[0] !== 32'h3 || bresp !== 2'b00) begin failures++; $display("FAIL fixed got data=%h bresp=%b required data=3 bresp=00", rb_data[0], bresp); end
    do_read(5'h06, 32'h20, 4'd3, 3'd1, 2'b01, 0, nb, un, y0, y1, y2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rb_data[i] !== 32'h0 || rb_resp[i] !== 4'h2) begin failures++; $display("FAIL bad_size beat=%0d got data=%h resp=%h required data=0 resp=2", i, rb_data[i], rb_resp[i]); end
    end
  endtask

  task automatic test_boundary();
    logic [4:0] bid; logic [1:0] bresp, eb; int un, nb; logic x0, x1, x2, x3, y0, y1, y2;
    for (int i = 0; i < 4; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
    set_wid(5'h09);
    do_write(5'h09, 32'h3F8, 4'd3, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h09, 32'h3F8, 4'd3, 3'd2, 2'b01, 1'b0, eb);
    checks++; if (bresp !== 2'b10) begin failures++; $display("FAIL bound_bresp got=%b required 10", bresp); end
    model_read(32'h3F8, 4'd3, 3'd2, 2'b01);
    do_read(5'h0B, 32'h3F8, 4'd3, 3'd2, 2'b01, 0, nb, un, y0, y1, y2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rb_data[i] !== ex_data[i] || rb_resp[i] !== ex_resp[i] || ex_resp[i] !== ((i >= 2) ? 4'h2 : 4'h0)) begin
        failures++; $display("FAIL bound_read beat=%0d got data=%h resp=%h required data=%h resp=%h", i, rb_data[i], rb_resp[i], ex_data[i], ex_resp[i]);
      end
    end
  endtask

  task automatic test_wlast();
    logic [4:0] bid; logic [1:0] bresp, eb; int un; logic x0, x1, x2, x3;
    for (int i = 0; i < 3; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
    set_wid(5'h07);
    do_write(5'h07, 32'h80, 4'd2, 3'd2, 2'b01, 1'b1, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h07, 32'h80, 4'd2, 3'd2, 2'b01, 1'b1, eb);
    checks++; if (bresp !== 2'b10 || bid !== 5'h07) begin failures++; $display("FAIL wlast got bid=%h bresp=%b required bid=07 bresp=10", bid, bresp); end
  endtask

  task automatic test_wid();
    logic [4:0] bid; logic [1:0] bresp, eb; int un, nb; logic x0, x1, x2, x3, y0, y1, y2;
    for (int i = 0; i < 3; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
    set_wid(5'h03);
    wb_wid[1] = 5'h13;
    do_write(5'h03, 32'h90, 4'd2, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
    model_write(5'h03, 32'h90, 4'd2, 3'd2, 2'b01, 1'b0, eb);
    checks++; if (bresp !== eb || bid !== 5'h03) begin failures++; $display("FAIL wid_b got bid=%h bresp=%b required bid=03 bresp=%b", bid, bresp, eb); end
    model_read(32'h90, 4'd2, 3'd2, 2'b01);
    do_read(5'h03, 32'h90, 4'd2, 3'd2, 2'b01, 0, nb, un, y0, y1, y2);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rb_data[i] !== ex_data[i]) begin failures++; $display("FAIL wid_read beat=%0d got=%h required=%h", i, rb_data[i], ex_data[i]); end
    end
  endtask

  task automatic test_random();
    logic [4:0] id, bid; logic [1:0] bresp, eb, burst; logic [2:0] size; logic [3:0] len;
    logic [31:0] addr; int un, nb; logic x0, x1, x2, x3, y0, y1, y2;
    for (int n = 0; n < 24; n++) begin
      id = 5'($urandom); addr = 32'($urandom_range(0, 32'h43F)); len = 4'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'($urandom); end
      set_wid(id);
      do_write(id, addr, len, size, burst, 1'b0, 0, bid, bresp, un, x0, x1, x2, x3);
      model_write(id, addr, len, size, burst, 1'b0, eb);
      checks++; if (bresp !== eb || bid !== id) begin failures++; $display("FAIL rand_b n=%0d got bid=%h bresp=%b required bid=%h bresp=%b", n, bid, bresp, id, eb); end
      id = 5'($urandom); addr = 32'($urandom_range(0, 32'h43F)); len = 4'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
      model_read(addr, len, size, burst);
      do_read(id, addr, len, size, burst, 2, nb, un, y0, y1, y2);
      checks++; if (nb !== int'(len) + 1 || un !== 0 || y1 !== 1'b0) begin failures++; $display("FAIL rand_rflow n=%0d got beats=%0d unstable=%0d rvalid_after=%b required %0d 0 0", n, nb, un, y1, int'(len) + 1); end
      for (int i = 0; i <= int'(len); i++) begin
        checks++;
        if (rb_data[i] !== ex_data[i] || rb_resp[i] !== ex_resp[i] || rb_last[i] !== (i == int'(len)) || rb_id[i] !== id) begin
          failures++;
          $display("FAIL rand_r n=%0d beat=%0d got data=%h resp=%h last=%b id=%h required data=%h resp=%h last=%b id=%h",
                   n, i, rb_data[i], rb_resp[i], rb_last[i], rb_id[i], ex_data[i], ex_resp[i], (i == int'(len)), id);
        end
      end
    end
  endtask

  task automatic test_concurrent();
    logic [4:0] bid; logic [1:0] bresp, eb; int wun, run, nb; logic x0, x1, x2, x3, y0, y1, y2;
    for (int i = 0; i < 16; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
    set_wid(5'h11);
    model_read(32'h200, 4'd15, 3'd2, 2'b01);
    fork
      do_write(5'h11, 32'h100, 4'd7, 3'd2, 2'b01, 1'b0, 5, bid, bresp, wun, x0, x1, x2, x3);
      do_read(5'h1C, 32'h200, 4'd15, 3'd2, 2'b01, 1, nb, run, y0, y1, y2);
    join
    model_write(5'h11, 32'h100, 4'd7, 3'd2, 2'b01, 1'b0, eb);
    checks++; if (bresp !== eb || bid !== 5'h11 || wun !== 0 || x2 !== 1'b1) begin failures++; $display("FAIL conc_b got bid=%h bresp=%b unstable=%0d bvalid=%b required bid=11 bresp=%b 0 1", bid, bresp, wun, x2, eb); end
    checks++; if (nb !== 16 || run !== 0 || y1 !== 1'b0) begin failures++; $display("FAIL conc_rflow got beats=%0d unstable=%0d rvalid_after=%b required 16 0 0", nb, run, y1); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rb_data[i] !== ex_data[i] || rb_last[i] !== (i == 15) || rb_id[i] !== 5'h1C) begin failures++; $display("FAIL conc_r beat=%0d got data=%h last=%b id=%h required data=%h last=%b id=1c", i, rb_data[i], rb_last[i], rb_id[i], ex_data[i], (i == 15)); end
    end
    model_read(32'h100, 4'd7, 3'd2, 2'b01);
    do_read(5'h00, 32'h100, 4'd7, 3'd2, 2'b01, 0, nb, run, y0, y1, y2);
    for (int i = 0; i < 8; i++) begin
      checks++; if (rb_data[i] !== ex_data[i]) begin failures++; $display("FAIL conc_wread beat=%0d got=%h required=%h", i, rb_data[i], ex_data[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] bid; logic [1:0] bresp, eb; int un; logic aw_busy, wr1, bv1, awa;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
      set_wid(5'(k + 20));
      do_write(5'(k + 20), 32'(32'hC0 + 32'(8 * k)), 4'd1, 3'd2, 2'b01, 1'b0, 0, bid, bresp, un, aw_busy, wr1, bv1, awa);
      model_write(5'(k + 20), 32'(32'hC0 + 32'(8 * k)), 4'd1, 3'd2, 2'b01, 1'b0, eb);
      checks++; if ({aw_busy, wr1, bv1, awa} !== 4'b0111 || bid !== 5'(k + 20) || bresp !== eb) begin
        failures++; $display("FAIL b2b k=%0d got timing=%b bid=%h bresp=%b required 0111 bid=%h bresp=%b", k, {aw_busy, wr1, bv1, awa}, bid, bresp, 5'(k + 20), eb);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb, un; logic y0, y1, y2;
    @(negedge clk);
    ARID = 5'h05; ARADDR = 32'h0; ARLEN = 4'd15; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (RVALID !== 1'b1) begin failures++; $display("FAIL midrst_pre rvalid=%b required 1", RVALID); end
    #2 clr = 1'b0;
    #1;
    checks++; if (RVALID !== 1'b0 || RLAST !== 1'b0) begin failures++; $display("FAIL midrst_async rvalid=%b rlast=%b required 0 0", RVALID, RLAST); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin failures++; $display("FAIL midrst_post arready=%b rvalid=%b required 1 0", ARREADY, RVALID); end
    model_read(32'h8, 4'd1, 3'd2, 2'b01);
    do_read(5'h06, 32'h8, 4'd1, 3'd2, 2'b01, 0, nb, un, y0, y1, y2);
    checks++; if (rb_data[0] !== ex_data[0] || rb_data[1] !== ex_data[1] || nb !== 2) begin failures++; $display("FAIL midrst_read got %h %h beats=%0d required %h %h 2", rb_data[0], rb_data[1], nb, ex_data[0], ex_data[1]); end
  endtask

  initial begin
    clr = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWLOCK = '0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARLOCK = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    test_reset();
    test_fill();
    test_incr_basic();
    test_strobe();
    test_fixed_and_size();
    test_boundary();
    test_wlast();
    test_wid();
    test_random();
    test_concurrent();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
